// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gen
// Brief    : Double-buffered PWM generator driven by an external free-running
//            counter, with start-up / run / end-of-period stop sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] count,
    input  logic         ovf,
    input  logic         cnt_en,
    input  logic [N:0]   duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    input  logic         stop,
    output logic         pwm,
    output logic         period_done,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [N:0] c_full_duty = {1'b1, {N{1'b0}}};

    state_t     r_state;
    state_t     w_state_nxt;
    logic [N:0] r_duty_sh;
    logic [N:0] r_duty_act;
    logic       r_pending;
    logic       r_stop_req;
    logic       r_period_done;

    logic       w_wrap;
    logic       w_accept;
    logic       w_clear;
    logic       w_load;
    logic [N:0] w_duty_clamped;

    assign w_wrap         = ovf & cnt_en;
    assign w_accept       = duty_valid & ~r_pending;
    assign w_duty_clamped = (duty_in > c_full_duty) ? c_full_duty : duty_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_clear wipes every duty register; stop always outranks a pending load.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (stop) begin
                    w_clear = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (stop) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_wrap) begin
                    if (r_stop_req) begin
                        w_clear     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load = r_pending;
                    end
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_sh     <= '0;
            r_duty_act    <= '0;
            r_pending     <= 1'b0;
            r_stop_req    <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= w_wrap && (r_state == S_RUN);
            if (w_clear) begin
                r_duty_sh  <= '0;
                r_duty_act <= '0;
                r_pending  <= 1'b0;
                r_stop_req <= 1'b0;
            end else begin
                // load and accept are exclusive: accept needs pending low
                if (w_load) begin
                    r_duty_act <= r_duty_sh;
                    r_pending  <= 1'b0;
                end
                if (w_accept) begin
                    r_duty_sh <= w_duty_clamped;
                    r_pending <= 1'b1;
                end
                if (stop && (r_state == S_RUN)) begin
                    r_stop_req <= 1'b1;
                end
            end
        end
    end

    assign pwm         = (r_state == S_RUN) && ({1'b0, count} < r_duty_act);
    assign duty_ready  = ~r_pending;
    assign period_done = r_period_done;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/pwm_gen.md
# pwm_gen

Duty-cycle generator that consumes the free-running 8-bit count and overflow flag of the structural counter and turns them into a PWM waveform. Duty values arrive over a valid/ready handshake and are double-buffered, so a new duty only takes effect at a period boundary, never mid-period. A small FSM sequences start-up, normal operation and a clean stop at the end of a period.

## Interface
- N, 8, counter width; the period is 2^N counter steps.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- count  in  N  counter value, driven by the counter's registered output.
- ovf  in  1  counter at all-ones (2^N-1).
- cnt_en  in  1  the same enable that drives the counter.
- duty_in  in  N+1  requested high time in counter steps, range 0..2^N.
- duty_valid  in  1  duty_in is valid.
- duty_ready  out  1  block can accept a duty value.
- stop  in  1  single-cycle request to stop at the end of the current period.
- pwm  out  1  PWM output.
- period_done  out  1  one-cycle pulse after each completed RUN period.
- busy  out  1  state is not IDLE.

## Operation
- wrap = ovf & cnt_en. This is the counter's 2^N-1 -> 0 transition at the next edge.
- Accept = duty_valid & duty_ready. On accept:
  - duty_sh <= min(duty_in, 2^N); values above 2^N clamp to 2^N.
  - pending <= 1.
- duty_ready = ~pending.
- On a wrap with pending=1:
  - duty_act <= duty_sh, pending <= 0.
  - Accept is impossible in the same cycle, because ready is low while pending.
- Accept in the same cycle as a wrap with pending=0: the value goes to the shadow and waits for the next wrap.
- FSM states:
  - IDLE: pwm=0. Accept -> ARMED.
  - ARMED: wait. A wrap loads duty_act -> RUN.
  - RUN: pwm = (count < duty_act), combinational from registered signals. duty_act=0 gives constant low; 2^N gives constant high.
- stop:
  - In IDLE or ARMED: -> IDLE at the next edge. pending, duty_sh and duty_act are cleared.
  - In RUN: sets stop_req. At the next wrap the state goes to IDLE, duty_act and stop_req clear, and pending/duty_sh are discarded.
- Stop vs. pending update: stop has priority over a pending duty update at the same wrap.
- period_done: registered. It is 1 for exactly the cycle after a wrap whose pre-edge state was RUN, including the final period before a stop.
- busy = (state != IDLE).
- Duty updates in RUN follow the shadow/pending rules above. The block does not leave RUN on its own.

## Timing
- Reset (synchronous):
  - State and registers: state=IDLE, duty_sh=0, duty_act=0, pending=0, stop_req=0.
  - Outputs: pwm=0, duty_ready=1, period_done=0, busy=0.
- Reset mid-period returns to IDLE at that edge. pwm is low from the following cycle.
- Handshake:
  - duty_ready falls on the edge after an accept.
  - duty_ready rises on the edge of the wrap that consumes the shadow.
  - duty_valid may stay high; only one transfer occurs per ready window.
- Latency of a new duty: the edge of the next wrap.
  - The first count=0 cycle after the wrap already uses the new duty.
  - Worst case is 2^N cycles after accept with cnt_en held high.
- With cnt_en low, count and wrap freeze. pwm holds its level, and no update or stop takes effect.
- pwm has zero cycles of latency relative to count, so it toggles in the same cycle count crosses duty_act.

## Test plan
- Reset, then duty_in=64 with valid held for 1 cycle, cnt_en=1 from count=0:
  - ARMED until the wrap at 255.
  - Next period: pwm high for counts 0..63 (64 cycles) and low for 192.
  - period_done pulses once per 256 cycles after the first RUN period.
- In RUN at duty 64, accept 200 at count=10:
  - The current period keeps 64.
  - duty_ready stays low until the wrap.
  - The next period is high for 200 cycles.
- Boundary duties:
  - 0 gives pwm constant low.
  - 256 gives pwm constant high across the wrap.
  - 300 clamps to 256, so pwm is constant high.
- Accept and wrap in the same cycle:
  - The value is applied one period later.
  - Toggle cnt_en low mid-period: pwm and count freeze, and no wrap is taken.
- stop asserted at count=100 in RUN (duty 128):
  - pwm finishes the period normally.
  - period_done pulses once.
  - Then IDLE: busy=0, pwm=0, and a pending shadow is discarded.
- rst asserted at count=30 in RUN with pwm high:
  - Next cycle pwm=0, busy=0, duty_ready=1.
  - A later wrap produces no period_done.
